sev_seg_scan_ctrl: RTL and testbench

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It latches a 16-bit hex value and scans the four digits one at a time. Each slot selects that digit's nibble, which is decoded through the team's hex-to-segment decoder, and drives the active-low anode, segment and decimal-point pins. The block sits between the datapath (for example, comparator results and counters) and the top-level display pins.

---
 rtl/sev_seg_pkg.sv | 34 +++
 rtl/loose_sev_sec_dec.sv | 30 +++
 rtl/sev_seg_scan_ctrl.sv | 103 ++++++++++
 tb/tb_sev_seg_scan_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sev_seg_pkg.sv
// Shared types, constants and helpers for the seven-segment scan controller.
// The anode and leading-zero helpers keep the top-level next-state logic short.
package sev_seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0]            SEG_OFF = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'hF;

  // One-hot active-low anode pattern for the selected digit.
  function automatic logic [NUM_DIGITS-1:0] an_active_n(input digit_idx_t idx);
    logic [NUM_DIGITS-1:0] onehot;
    onehot      = '0;
    onehot[idx] = 1'b1;
    return ~onehot;
  endfunction

  // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 always shows.
  function automatic logic lz_suppressed(input logic [15:0] v, input digit_idx_t idx);
    logic sup;
    sup = 1'b0;
    unique case (idx)
      2'd0: sup = 1'b0;
      2'd1: sup = (v[15:4] == 12'h000);
      2'd2: sup = (v[15:8] == 8'h00);
      2'd3: sup = (v[15:12] == 4'h0);
      default: sup = 1'b0;
    endcase
    return sup;
  endfunction

endpackage

// File: rtl/loose_sev_sec_dec.sv
// Hex nibble to active-low seven-segment decoder, segments ordered {g,f,e,d,c,b,a}.
module loose_sev_sec_dec (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_no
);

  always_comb begin
    seg_no = 7'h7F;
    unique case (nibble_i)
      4'h0: seg_no = 7'b1000000;
      4'h1: seg_no = 7'b1111001;
      4'h2: seg_no = 7'b0100100;
      4'h3: seg_no = 7'b0110000;
      4'h4: seg_no = 7'b0011001;
      4'h5: seg_no = 7'b0010010;
      4'h6: seg_no = 7'b0000010;
      4'h7: seg_no = 7'b1111000;
      4'h8: seg_no = 7'b0000000;
      4'h9: seg_no = 7'b0010000;
      4'hA: seg_no = 7'b0001000;
      4'hB: seg_no = 7'b0000011;
      4'hC: seg_no = 7'b1000110;
      4'hD: seg_no = 7'b0100001;
      4'hE: seg_no = 7'b0000110;
      4'hF: seg_no = 7'b0001110;
      default: seg_no = 7'h7F;
    endcase
  end

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Four-digit common-anode scan driver: shadows the display value, walks the digits
// with a prescaler and registers the active-low anode/segment/dp pins.
module sev_seg_scan_ctrl
  import sev_seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100_000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           value,
  input  logic                  load,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic                  lz_blank,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int unsigned     CntW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);

  if (REFRESH_DIV < 2 || BLANK_CYCLES >= REFRESH_DIV) begin : g_param_check
    $error("sev_seg_scan_ctrl: need REFRESH_DIV >= 2 and BLANK_CYCLES < REFRESH_DIV");
  end

  logic [CntW-1:0]       cnt_q, cnt_d;
  digit_idx_t            idx_q, idx_d;
  logic [15:0]           sh_value_q, sh_value_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0] sh_en_q, sh_en_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic [3:0] cur_nibble;
  logic [6:0] dec_seg;
  logic       slot_end;
  logic       lit;

  // Single decoder shared by all digits via the nibble mux.
  assign cur_nibble = sh_value_q[{idx_q, 2'b00} +: 4];

  loose_sev_sec_dec u_dec (
    .nibble_i (cur_nibble),
    .seg_no   (dec_seg)
  );

  assign slot_end = (cnt_q == CntLast);

  assign lit = (cnt_q >= CntBlank) && sh_en_q[idx_q] &&
               !(lz_blank && lz_suppressed(sh_value_q, idx_q));

  always_comb begin
    cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
    idx_d      = slot_end ? idx_q + 2'd1 : idx_q;
    sh_value_d = sh_value_q;
    sh_dp_d    = sh_dp_q;
    sh_en_d    = sh_en_q;
    if (load) begin
      sh_value_d = value;
      sh_dp_d    = dp_in;
      sh_en_d    = digit_en;
    end
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = an_active_n(idx_q);
      seg_d = dec_seg;
      dp_d  = ~sh_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_value_q <= 16'h0000;
      sh_dp_q    <= 4'h0;
      sh_en_q    <= 4'hF;
      an_q       <= AN_OFF;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_value_q <= sh_value_d;
      sh_dp_q    <= sh_dp_d;
      sh_en_q    <= sh_en_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Directed bench for sev_seg_scan_ctrl with REFRESH_DIV=4, BLANK_CYCLES=1.
module tb_sev_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int total = 0;
  int bad   = 0;

  sev_seg_scan_ctrl #(
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .load     (load),
    .dp_in    (dp_in),
    .digit_en (digit_en),
    .lz_blank (lz_blank),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  // Resets for one edge, then loads on the first edge after release. Returns at the
  // falling edge after that load edge; the next falling edge (j=0) shows digit 0 lit.
  task automatic restart(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] en);
    rst  = 1'b1;
    load = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    load     = 1'b1;
    value    = v;
    dp_in    = dpv;
    digit_en = en;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; value = 16'hABCD; dp_in = 4'hF; digit_en = 4'h0; lz_blank = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got an=%h seg=%h dp=%b, want an=f seg=7f dp=1",
                 i, an, seg, dp);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (an !== 4'hF || seg !== 7'h7F) begin
      bad++;
      $display("FAIL reset_first_blank: got an=%h seg=%h, want an=f seg=7f", an, seg);
    end
    @(negedge clk);
    total++;
    if (an !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_lit: got an=%h seg=%h dp=%b, want an=e seg=40 dp=1",
               an, seg, dp);
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] exp_seg [4] = '{7'h79, 7'h24, 7'h19, 7'h00};
    logic [3:0] ea;
    logic [6:0] es;
    lz_blank = 1'b0;
    restart(16'h8421, 4'h0, 4'hF);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      ea = (j % 4 == 3) ? 4'hF : exp_an[j / 4];
      es = (j % 4 == 3) ? 7'h7F : exp_seg[j / 4];
      total++;
      if (an !== ea || seg !== es || dp !== 1'b1) begin
        bad++;
        $display("FAIL scan[%0d]: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=1",
                 j, an, seg, dp, ea, es);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [3:0] an_lz   [4] = '{4'hE, 4'hD, 4'hF, 4'hF};
    logic [6:0] seg_lz  [4] = '{7'h40, 7'h30, 7'h7F, 7'h7F};
    logic [3:0] an_nlz  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] seg_nlz [4] = '{7'h40, 7'h30, 7'h40, 7'h40};
    logic [3:0] ea;
    logic [6:0] es;
    lz_blank = 1'b1;
    restart(16'h0030, 4'h0, 4'hF);
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      if (j % 4 == 3) begin
        ea = 4'hF; es = 7'h7F;
      end else if (j < 16) begin
        ea = an_lz[j / 4]; es = seg_lz[j / 4];
      end else begin
        ea = an_nlz[(j - 16) / 4]; es = seg_nlz[(j - 16) / 4];
      end
      total++;
      if (an !== ea || seg !== es) begin
        bad++;
        $display("FAIL lz[%0d] lz_blank=%b: got an=%h seg=%h, want an=%h seg=%h",
                 j, lz_blank, an, seg, ea, es);
      end
      if (j == 15) lz_blank = 1'b0;
    end
  endtask

  task automatic test_enable_dp();
    logic [3:0] exp_an  [4] = '{4'hE, 4'hF, 4'hB, 4'hF};
    logic [6:0] exp_seg [4] = '{7'h79, 7'h7F, 7'h19, 7'h7F};
    logic       exp_dp  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    lz_blank = 1'b0;
    restart(16'h8421, 4'b0001, 4'b0101);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      ea = (j % 4 == 3) ? 4'hF : exp_an[j / 4];
      es = (j % 4 == 3) ? 7'h7F : exp_seg[j / 4];
      ed = (j % 4 == 3) ? 1'b1 : exp_dp[j / 4];
      total++;
      if (an !== ea || seg !== es || dp !== ed) begin
        bad++;
        $display("FAIL en_dp[%0d]: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                 j, an, seg, dp, ea, es, ed);
      end
    end
  endtask

  task automatic test_mid_slot_load();
    lz_blank = 1'b0;
    restart(16'h8421, 4'h0, 4'hF);
    for (int j = 0; j < 9; j++) @(negedge clk);
    total++;
    if (an !== 4'hB || seg !== 7'h19) begin
      bad++;
      $display("FAIL midload_before: got an=%h seg=%h, want an=b seg=19", an, seg);
    end
    load = 1'b1; value = 16'hFFFF;
    @(negedge clk);
    total++;
    if (an !== 4'hB || seg !== 7'h19) begin
      bad++;
      $display("FAIL midload_load_edge: got an=%h seg=%h, want an=b seg=19", an, seg);
    end
    load = 1'b0; value = 16'h1234;
    @(negedge clk);
    total++;
    if (an !== 4'hB || seg !== 7'h0E) begin
      bad++;
      $display("FAIL midload_after: got an=%h seg=%h, want an=b seg=0e", an, seg);
    end
    for (int j = 11; j <= 16; j++) begin
      @(negedge clk);
      if (j == 12 || j == 16) begin
        total++;
        if (an !== ((j == 12) ? 4'h7 : 4'hE) || seg !== 7'h0E) begin
          bad++;
          $display("FAIL midload_noload[%0d]: got an=%h seg=%h, want seg=0e", j, an, seg);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    lz_blank = 1'b0;
    restart(16'h1234, 4'h0, 4'hF);
    for (int j = 0; j < 13; j++) @(negedge clk);
    total++;
    if (an !== 4'h7 || seg !== 7'h79) begin
      bad++;
      $display("FAIL midrst_before: got an=%h seg=%h, want an=7 seg=79", an, seg);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      bad++;
      $display("FAIL midrst_edge: got an=%h seg=%h dp=%b, want an=f seg=7f dp=1", an, seg, dp);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (an !== 4'hF || seg !== 7'h7F) begin
      bad++;
      $display("FAIL midrst_blank: got an=%h seg=%h, want an=f seg=7f", an, seg);
    end
    @(negedge clk);
    total++;
    if (an !== 4'hE || seg !== 7'h40) begin
      bad++;
      $display("FAIL midrst_cleared: got an=%h seg=%h, want an=e seg=40", an, seg);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_leading_zero();
    test_enable_dp();
    test_mid_slot_load();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
